// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and helpers for the stopwatch display path
package stopwatch_pkg;

    typedef enum logic {LIVE = 1'b0, LAP = 1'b1} lap_state_t;

    // Width of a digit index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - free-running digit scan prescaler and index counter
module scan_prescaler
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int N_DIGITS = 4,
    localparam int IDX_W   = idx_width(N_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [IDX_W-1:0] index
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] index_q, index_d;

    always_comb begin
        tick    = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        index_d = index_q;
        if (tick) begin
            index_d = (index_q == IDX_W'(N_DIGITS - 1)) ? '0 : index_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            index_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            index_q <= index_d;
        end
    end

    assign index = index_q;

endmodule

// File: rtl/lap_display_ctrl.sv
// rtl/lap_display_ctrl.sv - lap capture FSM and multiplexed 7-seg digit scan (LEADING_ZERO_BLANK_EN blanks leading zeros)
module lap_display_ctrl
    import stopwatch_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DIG_W    = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_DIGITS*DIG_W-1:0] live_digits,
    input  logic                      lap_btn,
    input  logic                      clr_btn,
    output logic                      mux_sel,
    output logic                      lap_active,
    output logic [DIG_W-1:0]          digit_val,
    output logic [N_DIGITS-1:0]       digit_en
);

    localparam int W     = N_DIGITS * DIG_W;
    localparam int IDX_W = idx_width(N_DIGITS);

    lap_state_t          state_q, state_d;
    logic [W-1:0]        lap_reg_q, lap_reg_d;
    logic                mux_sel_q, mux_sel_d;
    logic                lap_active_q, lap_active_d;
    logic [DIG_W-1:0]    digit_val_q, digit_val_d;
    logic [N_DIGITS-1:0] digit_en_q, digit_en_d;

    logic                tick;
    logic [IDX_W-1:0]    index;
    logic [IDX_W-1:0]    idx_next;
    logic [W-1:0]        src;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV),
        .N_DIGITS (N_DIGITS)
    ) u_scan (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .index (index)
    );

    // Clear dominates a simultaneous lap press, so no capture happens then.
    always_comb begin
        state_d   = state_q;
        lap_reg_d = lap_reg_q;
        if (clr_btn) begin
            state_d   = LIVE;
            lap_reg_d = '0;
        end else if (lap_btn) begin
            if (state_q == LIVE) begin
                state_d   = LAP;
                lap_reg_d = live_digits;
            end else begin
                state_d   = LIVE;
            end
        end
        mux_sel_d    = (state_d == LAP);
        lap_active_d = (state_d == LAP);
    end

    // Digit registers follow the index the prescaler moves to on this edge.
    always_comb begin
        src      = mux_sel_q ? lap_reg_q : live_digits;
        idx_next = index;
        if (tick) begin
            idx_next = (index == IDX_W'(N_DIGITS - 1)) ? '0 : index + 1'b1;
        end
        digit_val_d           = src[int'(idx_next) * DIG_W +: DIG_W];
        digit_en_d            = '0;
        digit_en_d[idx_next]  = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_next != '0) && ((src >> (int'(idx_next) * DIG_W)) == '0)) begin
            digit_en_d = '0;
        end
`else
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LIVE;
            lap_reg_q    <= '0;
            mux_sel_q    <= 1'b0;
            lap_active_q <= 1'b0;
            digit_val_q  <= '0;
            digit_en_q   <= N_DIGITS'(1);
        end else begin
            state_q      <= state_d;
            lap_reg_q    <= lap_reg_d;
            mux_sel_q    <= mux_sel_d;
            lap_active_q <= lap_active_d;
            digit_val_q  <= digit_val_d;
            digit_en_q   <= digit_en_d;
        end
    end

    assign mux_sel    = mux_sel_q;
    assign lap_active = lap_active_q;
    assign digit_val  = digit_val_q;
    assign digit_en   = digit_en_q;

endmodule

// File: tb/tb_lap_display_ctrl.sv
// tb/tb_lap_display_ctrl.sv - self-checking bench for lap_display_ctrl
module tb_lap_display_ctrl;

    localparam int ND = 4;
    localparam int DW = 4;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] live;
    logic        lap_btn;
    logic        clr_btn;
    logic        mux_sel;
    logic        lap_active;
    logic [3:0]  digit_val;
    logic [3:0]  digit_en;

    always #5 clk = ~clk;

    lap_display_ctrl #(
        .N_DIGITS (ND),
        .DIG_W    (DW),
        .SCAN_DIV (SD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .live_digits (live),
        .lap_btn     (lap_btn),
        .clr_btn     (clr_btn),
        .mux_sel     (mux_sel),
        .lap_active  (lap_active),
        .digit_val   (digit_val),
        .digit_en    (digit_en)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edges since reset, lap flag and lap value.
    int          m_t;
    bit          m_lap;
    logic [15:0] m_reg;
    logic        exp_mux;
    logic [3:0]  exp_val;
    logic [3:0]  exp_en;

    task automatic model_reset();
        m_t     = 0;
        m_lap   = 0;
        m_reg   = '0;
        exp_mux = 1'b0;
        exp_val = '0;
        exp_en  = 4'b0001;
    endtask

    task automatic model_edge(input logic [15:0] lv, input bit lb, input bit cb);
        logic [15:0] shown;
        int          idx;
        shown = m_lap ? m_reg : lv;
        if (cb) begin
            m_lap = 0;
            m_reg = '0;
        end else if (lb) begin
            if (!m_lap) begin
                m_reg = lv;
                m_lap = 1;
            end else begin
                m_lap = 0;
            end
        end
        m_t++;
        idx     = (m_t / SD) % ND;
        exp_mux = m_lap;
        exp_val = 4'((shown >> (4 * idx)) & 16'h000F);
        exp_en  = 4'(1 << idx);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx != 0 && (shown >> (4 * idx)) == 16'h0000) exp_en = 4'b0000;
`else
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(live, lap_btn, clr_btn);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " mux_sel"},    {31'd0, mux_sel},    {31'd0, exp_mux});
        check({tag, " lap_active"}, {31'd0, lap_active}, {31'd0, exp_mux});
        check({tag, " digit_val"},  {28'd0, digit_val},  {28'd0, exp_val});
        check({tag, " digit_en"},   {28'd0, digit_en},   {28'd0, exp_en});
    endtask

    task automatic check_reset(input string tag);
        check({tag, " mux_sel"},    {31'd0, mux_sel},    32'd0);
        check({tag, " lap_active"}, {31'd0, lap_active}, 32'd0);
        check({tag, " digit_val"},  {28'd0, digit_val},  32'd0);
        check({tag, " digit_en"},   {28'd0, digit_en},   32'd1);
    endtask

    typedef struct {
        logic [15:0] live;
        bit          lap;
        bit          clr;
        logic        mux;
        logic [3:0]  val;
        logic [3:0]  en;
    } vec_t;

    vec_t vecs[$];

    task automatic add_n(input int n, input logic [15:0] lv, input bit lb, input bit cb,
                         input logic mx, input logic [3:0] vl, input logic [3:0] en);
        vec_t v;
        v.live = lv; v.lap = lb; v.clr = cb; v.mux = mx; v.val = vl; v.en = en;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    logic [3:0] pat [4];

    initial begin
        rst = 1'b1; live = '0; lap_btn = 1'b0; clr_btn = 1'b0;

        // Each row is one clock edge starting at edge 1 after reset release.
        add_n(3, 16'h1234, 0, 0, 0, 4'h4, 4'b0001);
        add_n(4, 16'h1234, 0, 0, 0, 4'h3, 4'b0010);
        add_n(4, 16'h1234, 0, 0, 0, 4'h2, 4'b0100);
        add_n(4, 16'h1234, 0, 0, 0, 4'h1, 4'b1000);
        add_n(1, 16'h1234, 0, 0, 0, 4'h4, 4'b0001);
        add_n(1, 16'h1234, 1, 0, 1, 4'h4, 4'b0001);
        add_n(2, 16'h5678, 0, 0, 1, 4'h4, 4'b0001);
        add_n(4, 16'h5678, 0, 0, 1, 4'h3, 4'b0010);
        add_n(4, 16'h5678, 0, 0, 1, 4'h2, 4'b0100);
        add_n(4, 16'h5678, 0, 0, 1, 4'h1, 4'b1000);
        add_n(1, 16'h5678, 1, 0, 0, 4'h4, 4'b0001);
        add_n(3, 16'h5678, 0, 0, 0, 4'h8, 4'b0001);
        add_n(4, 16'h5678, 0, 0, 0, 4'h7, 4'b0010);
        add_n(4, 16'h5678, 0, 0, 0, 4'h6, 4'b0100);
        add_n(4, 16'h5678, 0, 0, 0, 4'h5, 4'b1000);
        add_n(1, 16'h5678, 1, 1, 0, 4'h8, 4'b0001);
        add_n(1, 16'h5678, 0, 0, 0, 4'h8, 4'b0001);

        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        check("reset lap_reg", 32'(dut.lap_reg_q), 32'd0);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            live = vecs[i].live; lap_btn = vecs[i].lap; clr_btn = vecs[i].clr;
            step();
            lap_btn = 1'b0; clr_btn = 1'b0;
            check($sformatf("vec%0d mux_sel", i),    {31'd0, mux_sel},    {31'd0, vecs[i].mux});
            check($sformatf("vec%0d lap_active", i), {31'd0, lap_active}, {31'd0, vecs[i].mux});
            check($sformatf("vec%0d digit_val", i),  {28'd0, digit_val},  {28'd0, vecs[i].val});
            check($sformatf("vec%0d digit_en", i),   {28'd0, digit_en},   {28'd0, vecs[i].en});
            if (i == 46) check("lap_reg kept after release", 32'(dut.lap_reg_q), 32'h1234);
        end
        check("clr wins lap_reg", 32'(dut.lap_reg_q), 32'd0);

        // Asynchronous reset in LAP, mid-digit.
        live = 16'h4321; lap_btn = 1'b1;
        step();
        lap_btn = 1'b0;
        repeat (5) step();
        check_model("pre_rst");
        #2 rst = 1'b1;
        #1;
        check_reset("async_rst");
        @(posedge clk);
        #1;
        check_reset("rst_held");
        rst = 1'b0;
        model_reset();

        // Leading-zero pattern over one full refresh.
        pat[0] = 4'b0001;
        pat[1] = 4'b0010;
`ifdef LEADING_ZERO_BLANK_EN
        pat[2] = 4'b0000;
        pat[3] = 4'b0000;
`else
        pat[2] = 4'b0100;
        pat[3] = 4'b1000;
`endif
        live = 16'h0070;
        for (int t = 1; t <= 16; t++) begin
            step();
            check_model($sformatf("lz t%0d", t));
            if (t % 4 == 2) check($sformatf("lz slot%0d", t / 4), {28'd0, digit_en}, {28'd0, pat[t / 4]});
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] lv;
            for (int d = 0; d < 4; d++) begin
                lv[d*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 9));
            end
            live    = lv;
            lap_btn = ($urandom_range(0, 7) == 0);
            clr_btn = ($urandom_range(0, 15) == 0);
            step();
            check_model($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
